// File: rtl/loong_pkg.sv
// Shared constants, types and FSM encoding for the LOONG_ENC core arbiter.
package loong_pkg;
   localparam int NIBBLES = 16;
   localparam int BLOCK_W = 64;

   typedef logic [3:0]         nibble_t;
   typedef logic [BLOCK_W-1:0] block_t;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} arb_state_t;
endpackage

// File: rtl/loong_rr_picker.sv
// Combinational one-hot picker: first valid requester after i_rr_ptr, wrapping.
// LOONG_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins, i_rr_ptr ignored).
module loong_rr_picker
   import loong_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [IDW-1:0]     i_rr_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDW-1:0]     o_grant_id
);
   int   w_idx;
   logic w_found;

   always_comb begin
      o_grant    = '0;
      o_grant_id = '0;
      w_found    = 1'b0;
      w_idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef LOONG_ARB_FIXED_PRIO_EN
         w_idx = k;
`else
         // Search starts one past the last winner so it drops to lowest priority.
         w_idx = int'(i_rr_ptr) + 1 + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
`endif
         if (!w_found && i_req_valid[w_idx]) begin
            w_found          = 1'b1;
            o_grant[w_idx]   = 1'b1;
            o_grant_id       = IDW'(w_idx);
         end
      end
   end
endmodule

// File: rtl/loong_core_arbiter.sv
// Shares one LOONG_ENC core among NUM_REQ requesters: arbitrate, pulse do_loong, wait, return result.
// Define LOONG_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module loong_core_arbiter
   import loong_pkg::*;
#(
   parameter  int NUM_REQ      = 2,
   parameter  int CORE_LATENCY = 20,
   localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*BLOCK_W-1:0] req_plaintext,
   input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic [BLOCK_W-1:0]         rsp_ciphertext,
   output logic                       core_do_loong,
   output logic [BLOCK_W-1:0]         core_plaintext,
   output logic [BLOCK_W-1:0]         core_round_key,
   input  logic [BLOCK_W-1:0]         core_ciphertext
);
   localparam int CNTW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;

   arb_state_t       r_state;
   logic [IDW-1:0]   r_id;
   logic [CNTW-1:0]  r_cnt;
   logic             r_rsp_valid;
   logic [IDW-1:0]   r_rsp_id;
   block_t           r_rsp_ct;
   logic             r_do;
   block_t           r_pt;
   block_t           r_key;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDW-1:0]     w_grant_id;
   logic [IDW-1:0]     w_rr_ptr;
   logic               w_accept;
   block_t             w_pt_arr  [NUM_REQ];
   block_t             w_key_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_pt_arr[g]  = req_plaintext[g*BLOCK_W +: BLOCK_W];
      assign w_key_arr[g] = req_key[g*BLOCK_W +: BLOCK_W];
   end

`ifdef LOONG_ARB_FIXED_PRIO_EN
   assign w_rr_ptr = '0;
`else
   logic [IDW-1:0] r_rr_ptr;
   assign w_rr_ptr = r_rr_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        r_rr_ptr <= IDW'(NUM_REQ-1);
      else if (w_accept) r_rr_ptr <= w_grant_id;
   end
`endif

   loong_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req_valid (req_valid),
      .i_rr_ptr    (w_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_id  (w_grant_id)
   );

   // Grant only while idle; the picker output is already qualified by req_valid.
   assign req_ready = (r_state == IDLE) ? w_grant : '0;
   assign w_accept  = (r_state == IDLE) && (|w_grant);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_id        <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_ct    <= '0;
         r_do        <= 1'b0;
         r_pt        <= '0;
         r_key       <= '0;
      end else begin
         r_do <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_pt    <= w_pt_arr[w_grant_id];
               r_key   <= w_key_arr[w_grant_id];
               r_id    <= w_grant_id;
               r_do    <= 1'b1;
               r_state <= LAUNCH;
            end
            LAUNCH: begin
               r_cnt   <= CNTW'(CORE_LATENCY-1);
               r_state <= WAIT;
            end
            WAIT: if (r_cnt == '0) begin
               r_rsp_ct    <= core_ciphertext;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= RESPOND;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            RESPOND: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid      = r_rsp_valid;
   assign rsp_id         = r_rsp_id;
   assign rsp_ciphertext = r_rsp_ct;
   assign core_do_loong  = r_do;
   assign core_plaintext = r_pt;
   assign core_round_key = r_key;
endmodule

// File: tb/tb_loong_core_arbiter.sv
// Bench for loong_core_arbiter: core model returns pt^key, scoreboard plus vector table and corner sequences.
module tb_loong_core_arbiter;
   import loong_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int L       = 20;
   localparam int IDW     = 1;
   localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*64-1:0]  req_plaintext = '0;
   logic [NUM_REQ*64-1:0]  req_key = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b1;
   logic [IDW-1:0]         rsp_id;
   logic [63:0]            rsp_ciphertext;
   logic                   core_do_loong;
   logic [63:0]            core_plaintext;
   logic [63:0]            core_round_key;
   logic [63:0]            core_ciphertext = JUNK;

   always #5 clk = ~clk;

   loong_core_arbiter #(.NUM_REQ(NUM_REQ), .CORE_LATENCY(L)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_plaintext   (req_plaintext),
      .req_key         (req_key),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_ciphertext  (rsp_ciphertext),
      .core_do_loong   (core_do_loong),
      .core_plaintext  (core_plaintext),
      .core_round_key  (core_round_key),
      .core_ciphertext (core_ciphertext)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef LOONG_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
`else
      for (int k = 1; k <= NUM_REQ; k++) if (v[(ptr+k) % NUM_REQ]) return (ptr+k) % NUM_REQ;
`endif
      return 0;
   endfunction

   typedef struct {
      logic [IDW-1:0] id;
      logic [63:0]    ct;
      int             acc;
   } exp_t;
   exp_t sbq[$];

   int          cyc = 0, rem = -1, m_ptr = NUM_REQ-1, w_m = 0;
   int          acc_cnt = 0, rsp_cnt = 0, rise_cnt = 0, last_acc = -100, last_hs = -100;
   bit          busy = 0, prev_do = 0, prev_rv = 0;
   logic [63:0] cpt = '0, ckey = '0, prev_ct = '0, got_ct = '0, oh;
   logic [IDW-1:0] prev_id = '0, got_id = '0;

   // Core model, scoreboard and protocol monitor, all sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         rem = -1; sbq.delete(); busy = 0; m_ptr = NUM_REQ-1;
         prev_do = 0; prev_rv = 0; core_ciphertext = JUNK;
      end else begin
         if (core_do_loong) begin
            chk("do_loong_lat", 64'(cyc), 64'(last_acc + 1));
            chk("do_loong_single", 64'(prev_do), 64'd0);
            rem = L; cpt = core_plaintext; ckey = core_round_key;
         end else if (rem >= 0) rem--;
         core_ciphertext = (rem == 0) ? (cpt ^ ckey) : JUNK;

         if (busy && req_valid != '0) chk("ready_busy", 64'(req_ready), 64'd0);
         if (!busy && req_valid != '0) begin
            w_m = model_pick(req_valid, m_ptr);
            oh  = 64'd1 << w_m;
            chk("grant", 64'(req_ready), oh);
         end
         if ((req_valid & req_ready) != '0) begin
            sbq.push_back('{id: IDW'(w_m),
                            ct: req_plaintext[64*w_m +: 64] ^ req_key[64*w_m +: 64],
                            acc: cyc});
            m_ptr = w_m; busy = 1; last_acc = cyc; acc_cnt++;
         end

         if (rsp_valid) begin
            if (sbq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            else begin
               if (!prev_rv) begin
                  chk("rsp_latency", 64'(cyc), 64'(sbq[0].acc + 2 + L));
                  rise_cnt++;
               end else begin
                  chk("rsp_hold_id", 64'(rsp_id), 64'(prev_id));
                  chk("rsp_hold_ct", rsp_ciphertext, prev_ct);
               end
               if (rsp_ready) begin
                  chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
                  chk("rsp_ct", rsp_ciphertext, sbq[0].ct);
                  got_id = rsp_id; got_ct = rsp_ciphertext;
                  void'(sbq.pop_front());
                  busy = 0; last_hs = cyc; rsp_cnt++;
               end
            end
         end
         prev_do = core_do_loong; prev_rv = rsp_valid; prev_id = rsp_id; prev_ct = rsp_ciphertext;
      end
   end

   task automatic wait_acc(input int target, input string nm);
      int t = 0;
      while (acc_cnt < target && t < 200) begin @(posedge clk); t++; end
      if (acc_cnt < target) chk({nm, "_acc_timeout"}, 64'(acc_cnt), 64'(target));
   endtask

   task automatic wait_rsp(input int target, input string nm);
      int t = 0;
      while (rsp_cnt < target && t < 200) begin @(posedge clk); t++; end
      if (rsp_cnt < target) chk({nm, "_rsp_timeout"}, 64'(rsp_cnt), 64'(target));
   endtask

   task automatic wait_rise(input int target, input string nm);
      int t = 0;
      while (rise_cnt < target && t < 200) begin @(posedge clk); t++; end
      if (rise_cnt < target) chk({nm, "_rise_timeout"}, 64'(rise_cnt), 64'(target));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
      chk({tag, "_rsp_ct"}, rsp_ciphertext, 64'd0);
      chk({tag, "_do_loong"}, 64'(core_do_loong), 64'd0);
      chk({tag, "_core_pt"}, core_plaintext, 64'd0);
      chk({tag, "_core_key"}, core_round_key, 64'd0);
   endtask

   typedef struct {
      logic [NUM_REQ-1:0] vld;
      logic               hold;
      logic [63:0]        pt0, k0, pt1, k1;
      logic [IDW-1:0]     exp_id;
      logic [63:0]        exp_ct;
   } vec_t;

   localparam logic [63:0] PA = 64'h1111_2222_3333_4444, KA = 64'h0F0F_0F0F_0F0F_0F0F;
   localparam logic [63:0] PB = 64'hA5A5_A5A5_A5A5_A5A5, KB = 64'h0000_FFFF_0000_FFFF;
   localparam logic [63:0] CA = 64'h1E1E_2D2D_3C3C_4B4B, CB = 64'hA5A5_5A5A_A5A5_5A5A;

   initial begin
      vec_t tbl [5];
      int   base;
`ifdef LOONG_ARB_FIXED_PRIO_EN
      tbl[0] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b0, CA};
      tbl[1] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b0, CA};
      tbl[2] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b0, CA};
      tbl[3] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b0, CA};
`else
      tbl[0] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b0, CA};
      tbl[1] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b1, CB};
      tbl[2] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b0, CA};
      tbl[3] = '{2'b11, 1'b1, PA, KA, PB, KB, 1'b1, CB};
`endif
      tbl[4] = '{2'b01, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 PB, KB, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};

      // Reset state
      repeat (3) @(posedge clk);
      #2 chk_reset_vals("reset");
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);

      // Vector table: contention then a single request
      for (int i = 0; i < 5; i++) begin
         #1;
         req_valid = tbl[i].vld;
         req_plaintext = {tbl[i].pt1, tbl[i].pt0};
         req_key       = {tbl[i].k1, tbl[i].k0};
         base = acc_cnt;
         wait_acc(base + 1, "tbl");
         if (!tbl[i].hold) begin #1 req_valid = '0; end
         wait_rsp(base + 1, "tbl");
         chk($sformatf("tbl%0d_id", i), 64'(got_id), 64'(tbl[i].exp_id));
         chk($sformatf("tbl%0d_ct", i), got_ct, tbl[i].exp_ct);
      end

      // Back-pressure with a one-cycle valid pulse from req1 while busy
      #1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_plaintext[63:0] = 64'h0011_2233_4455_6677;
      req_key[63:0]       = 64'h8899_AABB_CCDD_EEFF;
      req_valid = 2'b01;
      base = acc_cnt;
      wait_acc(base + 1, "bp");
      #1 req_valid = '0;
      wait_rise(rise_cnt + 1, "bp");
      #1 req_valid = 2'b10;
      @(posedge clk); #1 req_valid = 2'b00;
      repeat (8) @(posedge clk);
      #1;
      req_plaintext[63:0] = 64'hCAFE_BABE_1234_5678;
      req_key[63:0]       = 64'hFFFF_FFFF_0000_0000;
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      wait_rsp(rsp_cnt + 1, "bp");
      chk("bp_ct", got_ct, 64'h8888_8888_8888_8888);
      wait_acc(base + 2, "bp_next");
      chk("acc_after_rsp", 64'(last_acc), 64'(last_hs + 1));
      #1 req_valid = '0;
      wait_rsp(rsp_cnt + 1, "wd");
      chk("withdraw_id", 64'(got_id), 64'd0);
      chk("withdraw_ct", got_ct, 64'h3501_4541_1234_5678);

      // Reset in the middle of WAIT
      #1;
      req_plaintext[63:0] = 64'h0F1E_2D3C_4B5A_6978;
      req_key[63:0]       = 64'h1111_1111_1111_1111;
      req_valid = 2'b01;
      wait_acc(acc_cnt + 1, "rst");
      #1 req_valid = '0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b0;
      #2 chk_reset_vals("midreset");
      @(posedge clk); #1;
      reset = 1'b1;
      req_plaintext = {PB, PA};
      req_key       = {KB, KA};
      req_valid = 2'b11;
      wait_acc(acc_cnt + 1, "post_rst");
      #1 req_valid = '0;
      wait_rsp(rsp_cnt + 1, "post_rst");
      chk("post_reset_id", 64'(got_id), 64'd0);
      chk("post_reset_ct", got_ct, CA);

      repeat (5) @(posedge clk);
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/loong_core_arbiter.md
Name: loong_core_arbiter

Overview:
Shares one LOONG_ENC encryption core between NUM_REQ requesters, such as a UART frame loader and a test/DMA port. Each requester supplies a 64-bit plaintext and a 64-bit round key through a valid/ready handshake. A round-robin arbiter selects one requester and the block drives the core's one-cycle do_loong start pulse. It then counts a fixed core latency, captures the ciphertext and returns it with the requester ID over a valid/ready response channel. The block sits between the frame-parsing front end and LOONG_ENC.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CORE_LATENCY, 20, cycles from the do_loong pulse until core_ciphertext is valid (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  request pending, one bit per requester
req_ready  output  NUM_REQ  one-hot grant/accept
req_plaintext  input  NUM_REQ*64  per-requester plaintext; requester r at [64r+63:64r]; nibble i at [4i+3:4i]
req_key  input  NUM_REQ*64  per-requester round key, same packing as req_plaintext
rsp_valid  output  1  ciphertext result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  $clog2(NUM_REQ) (min 1)  requester index of the result
rsp_ciphertext  output  64  ciphertext, 16 nibbles
core_do_loong  output  1  single-cycle start pulse to the core
core_plaintext  output  64  registered operand to the core
core_round_key  output  64  registered operand to the core
core_ciphertext  input  64  core result

Behaviour:
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_ciphertext=0; core_do_loong=0; core_plaintext=0; core_round_key=0; rr_ptr=NUM_REQ-1, so requester 0 wins first.
- FSM states and transitions:
  - IDLE: winner = first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. req_ready[winner]=1, combinational, only in IDLE. On req_valid&req_ready: latch plaintext, key and id; rr_ptr<=winner; go to LAUNCH. With no valid request, stay in IDLE.
  - LAUNCH: core_do_loong=1 for exactly this cycle; cnt<=CORE_LATENCY-1; go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt==0: rsp_ciphertext<=core_ciphertext, rsp_id<=latched id, go to RESPOND.
  - RESPOND: rsp_valid=1, with rsp_id and rsp_ciphertext held stable. On rsp_ready go to IDLE; otherwise hold indefinitely.
- core_plaintext and core_round_key are held stable from LAUNCH until the next accept.
- Latency: accept at cycle T, do_loong at T+1, ciphertext sampled at T+1+CORE_LATENCY, rsp_valid from T+2+CORE_LATENCY.
- Minimum spacing: 3+CORE_LATENCY cycles between accepts, because the next accept is no earlier than the cycle after the response handshake.
- Only one operation is in flight at a time. req_ready stays 0 in LAUNCH, WAIT and RESPOND.
- Requesters must hold req_valid and data until ready. If req_valid drops early, the winner is simply re-evaluated the next cycle and nothing is latched.
- The rr_ptr update happens only on an accept; it wraps from NUM_REQ-1 to 0.
- Reset asserted mid-operation returns the block to IDLE immediately and discards any pending result. The core shares the same reset.

Optional Feature:
LOONG_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented.
- Undefined (default): round robin as specified above.

Decomposition:
- Package loong_pkg holds:
  - NIBBLES=16 and BLOCK_W=64 constants
  - nibble_t (logic [3:0]) and block_t (logic [63:0]) typedefs
  - the arb_state_t enum {IDLE, LAUNCH, WAIT, RESPOND}
- One sub-module, loong_rr_picker: combinational rotating-priority one-hot picker taking req_valid and rr_ptr.
- The optional-feature macro selects the picker's fixed-priority mode.

Test Plan:
- Single request: req0 with pt=0x0123456789ABCDEF and key=0xFEDCBA9876543210, core model returning pt^key after 20 cycles -> do_loong at T+1, rsp_valid at T+22, rsp_id=0, rsp_ciphertext=0xFFFFFFFFFFFFFFFF.
- Contention: req0 and req1 valid continuously for 4 operations -> grant order 0,1,0,1; no overlap of do_loong pulses.
- Back-pressure: rsp_ready=0 for 10 cycles in RESPOND -> rsp_valid and data stable; req_ready stays 0; accept is possible the cycle after rsp_ready.
- Reset mid-WAIT: reset low at cycle T+8 -> all outputs return to reset values; no rsp_valid; req0 wins first after release.
- Valid withdrawal: req1 pulses valid for 1 cycle while busy -> not latched; next grant goes to the still-valid req0.
- With LOONG_ARB_FIXED_PRIO_EN defined: both requesters continuously valid for 3 ops -> grants 0,0,0.
